// File: rtl/bep_bit_recovery.sv
// BEP radio bit recovery: synchronises the raw line, tracks bursts and emits one strobe per bit.
// Optional majority glitch filter on the synchronised line: define BEP_GLITCH_FILTER_EN.
module bep_bit_recovery #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned IDLE_BITS    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic       serial_data,
    output logic       serial_clock,
    output logic       active,
    output logic       burst_end,
    output logic [7:0] bit_count
);

    localparam int unsigned HALF    = CLKS_PER_BIT / 2;
    localparam int unsigned PW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned TIMEOUT = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IW      = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t          state;
    logic            s1;
    logic            s2;
    logic            rx_clean;
    logic            rx_prev;
    logic            edge_seen;
    logic [PW-1:0]   phase;
    logic [IW-1:0]   idle_cnt;

`ifdef BEP_GLITCH_FILTER_EN
    logic d1;
    logic d2;
    logic filt;

    // A lone one-cycle pulse never overlaps its own delayed copies, so 2-of-3 drops it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            d1   <= 1'b0;
            d2   <= 1'b0;
            filt <= 1'b0;
        end else begin
            d1   <= s2;
            d2   <= d1;
            filt <= (s2 & d1) | (s2 & d2) | (d1 & d2);
        end
    end

    assign rx_clean = filt;
`else
    assign rx_clean = s2;
`endif

    assign edge_seen = (rx_clean != rx_prev);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            rx_prev      <= 1'b0;
            phase        <= '0;
            idle_cnt     <= '0;
            serial_data  <= 1'b0;
            serial_clock <= 1'b0;
            active       <= 1'b0;
            burst_end    <= 1'b0;
            bit_count    <= '0;
        end else begin
            s1           <= rx_in;
            s2           <= s1;
            rx_prev      <= rx_clean;
            serial_clock <= 1'b0;
            burst_end    <= 1'b0;
            case (state)
                IDLE: begin
                    phase    <= '0;
                    idle_cnt <= '0;
                    if (edge_seen) begin
                        state     <= ACTIVE;
                        active    <= 1'b1;
                        bit_count <= '0;
                    end
                end
                ACTIVE: begin
                    if (edge_seen) begin
                        // An edge outranks both the mid-bit sample and the timeout.
                        phase    <= '0;
                        idle_cnt <= '0;
                    end else begin
                        if (phase == PW'(CLKS_PER_BIT - 1))
                            phase <= '0;
                        else
                            phase <= phase + 1'b1;

                        if (phase == PW'(HALF)) begin
                            serial_clock <= 1'b1;
                            serial_data  <= rx_clean;
                            if (bit_count != 8'hFF)
                                bit_count <= bit_count + 8'd1;
                        end

                        if (idle_cnt == IW'(TIMEOUT - 1)) begin
                            state     <= IDLE;
                            active    <= 1'b0;
                            burst_end <= 1'b1;
                            phase     <= '0;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bep_bit_recovery.sv
// Directed bench for bep_bit_recovery: line segments drive rx_in, expected strobes go to a scoreboard.
// Expectations shift by two cycles when built with BEP_GLITCH_FILTER_EN.
module tb_bep_bit_recovery;

`ifdef BEP_GLITCH_FILTER_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_in = 1'b0;
    logic       serial_data;
    logic       serial_clock;
    logic       active;
    logic       burst_end;
    logic [7:0] bit_count;

    typedef struct {
        int unsigned t;
        logic        d;
        logic [7:0]  c;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned be_at = 32'hFFFF_FFFF;
    int unsigned vectors = 0;
    int unsigned errors = 0;
    logic [7:0]  bc = 8'd0;
    bit          idle = 1'b1;

    bep_bit_recovery #(.CLKS_PER_BIT(8), .IDLE_BITS(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_in(rx_in),
        .serial_data(serial_data),
        .serial_clock(serial_clock),
        .active(active),
        .burst_end(burst_end),
        .bit_count(bit_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Strobes expected from a line change sampled at edge t0 followed by n cycles of value v.
    task automatic expect_seg(input logic v, input int unsigned n, input int unsigned t0);
        if (idle) begin
            bc   = 8'd0;
            idle = 1'b0;
        end
        for (int unsigned k = 0; (8*k + 5 < n) && (8*k + 6 <= 33); k++) begin
            if (bc != 8'hFF) bc = bc + 8'd1;
            q.push_back('{t: t0 + 7 + 8*k + LAT, d: v, c: bc});
        end
        if (n >= 33) begin
            be_at = t0 + 34 + LAT;
            idle  = 1'b1;
        end
    endtask

    task automatic seg(input logic v, input int unsigned n, input bit dopush);
        int unsigned t0;
        t0 = cyc + 1;
        rx_in = v;
        if (dopush) expect_seg(v, n, t0);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0 && q[0].t == cyc) begin
            exp_t e;
            e = q.pop_front();
            check("strobe", {31'd0, serial_clock}, 32'd1);
            check("data", {31'd0, serial_data}, {31'd0, e.d});
            check("bit_count", {24'd0, bit_count}, {24'd0, e.c});
        end else begin
            check("no_strobe", {31'd0, serial_clock}, 32'd0);
        end
        check("burst_end", {31'd0, burst_end}, {31'd0, (cyc == be_at)});
        if (cyc == be_at) check("active_fall", {31'd0, active}, 32'd0);
    end

    initial begin
        int unsigned t0;

        // Reset held while the line toggles
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_in = ~rx_in;
            @(posedge clock);
            #1;
            check("rst_active", {31'd0, active}, 32'd0);
            check("rst_count", {24'd0, bit_count}, 32'd0);
            check("rst_data", {31'd0, serial_data}, 32'd0);
        end
        rx_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle_active", {31'd0, active}, 32'd0);

        // Preamble 1010... at 8 cycles per bit
        for (int i = 0; i < 8; i++) seg((i % 2 == 0) ? 1'b1 : 1'b0, 8, 1'b1);
        check("pre_active", {31'd0, active}, 32'd1);

        // Slow transmitter: 9 cycles per bit
        for (int i = 0; i < 32; i++) seg((i % 2 == 0) ? 1'b1 : 1'b0, 9, 1'b1);

        // Edge lands exactly on the mid-bit sample cycle
        seg(1'b1, 5, 1'b1);
        seg(1'b0, 8, 1'b1);

        // Edge lands on the timeout cycle: burst continues
        seg(1'b1, 32, 1'b1);
        seg(1'b0, 8, 1'b1);
        check("edge_timeout_active", {31'd0, active}, 32'd1);

        // Constant run into timeout, then restart
        seg(1'b1, 8, 1'b1);
        seg(1'b0, 40, 1'b1);
        check("timeout_active", {31'd0, active}, 32'd0);
        seg(1'b1, 8, 1'b1);

        // One-cycle glitch inside a low bit
`ifdef BEP_GLITCH_FILTER_EN
        t0 = cyc + 1;
        expect_seg(1'b0, 16, t0);
        seg(1'b0, 3, 1'b0);
        seg(1'b1, 1, 1'b0);
        seg(1'b0, 12, 1'b0);
`else
        seg(1'b0, 3, 1'b1);
        seg(1'b1, 1, 1'b1);
        seg(1'b0, 12, 1'b1);
`endif
        seg(1'b1, 8, 1'b1);

        // Reset in the middle of a burst
        seg(1'b0, 12, 1'b1);
        check("pre_rst_active", {31'd0, active}, 32'd1);
        check("pre_rst_count", {24'd0, bit_count}, {24'd0, bc});
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_active", {31'd0, active}, 32'd0);
        check("mid_rst_count", {24'd0, bit_count}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Fresh burst ending in timeout
        seg(1'b1, 40, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        check("end_active", {31'd0, active}, 32'd0);
        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
